// File: rtl/pipeline_pkg.sv
// Shared definitions for the integer pipeline: datapath width, ALU operation
// encoding, execute-stage states and the word sign-extension helper.
package pipeline_pkg;

  localparam int XLEN       = 64;
  localparam int WORD_W     = 32;
  localparam int DIV_ITER_W = $clog2(XLEN);

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_LUI, OP_AUIPC,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } exec_state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [WORD_W-1:0] v);
    return {{(XLEN-WORD_W){v[WORD_W-1]}}, v};
  endfunction

endpackage

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider on operand magnitudes with sign fix-up on the last
// iteration; divide-by-zero and signed overflow are flagged for the caller.
module iterative_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        word,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        special,
  output logic [63:0] special_quo,
  output logic [63:0] special_rem,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);
  import pipeline_pkg::*;

  localparam logic [DIV_ITER_W-1:0] LAST_D = DIV_ITER_W'(XLEN - 1);
  localparam logic [DIV_ITER_W-1:0] LAST_W = DIV_ITER_W'(WORD_W - 1);

  logic [XLEN-1:0]       rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [DIV_ITER_W-1:0] cnt_q, cnt_d;
  logic                  active_q, active_d, word_q, word_d;
  logic                  negq_q, negq_d, negr_q, negr_d;

  logic                  neg_a_s, neg_b_s, div_zero_s, overflow_s, ge_s;
  logic [XLEN-1:0]       mag_a_s, mag_b_s, min_val_s, rem_next_s, quo_next_s, q_mag_s;
  logic [XLEN:0]         rem_shift_s;

  // Special-case detection and operand magnitudes from the live inputs.
  always_comb begin
    neg_a_s     = is_signed & dividend[XLEN-1];
    neg_b_s     = is_signed & divisor[XLEN-1];
    mag_a_s     = neg_a_s ? (-dividend) : dividend;
    mag_b_s     = neg_b_s ? (-divisor) : divisor;
    min_val_s   = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero_s  = (divisor == {XLEN{1'b0}});
    overflow_s  = is_signed & (dividend == min_val_s) & (divisor == {XLEN{1'b1}});
    special     = div_zero_s | overflow_s;
    special_quo = div_zero_s ? {XLEN{1'b1}} : dividend;
    special_rem = div_zero_s ? dividend : {XLEN{1'b0}};
  end

  // One restoring step; results are taken from the step that sets done.
  always_comb begin
    rem_shift_s = {rem_q, quo_q[XLEN-1]};
    ge_s        = (rem_shift_s >= {1'b0, dvs_q});
    rem_next_s  = ge_s ? XLEN'(rem_shift_s - {1'b0, dvs_q}) : rem_shift_s[XLEN-1:0];
    quo_next_s  = {quo_q[XLEN-2:0], ge_s};
    done        = active_q & (cnt_q == (word_q ? LAST_W : LAST_D));
    q_mag_s     = word_q ? {{(XLEN-WORD_W){1'b0}}, quo_next_s[WORD_W-1:0]} : quo_next_s;
    quotient    = negq_q ? (-q_mag_s) : q_mag_s;
    remainder   = negr_q ? (-rem_next_s) : rem_next_s;
  end

  // Next-state: word mode parks the dividend in the upper half so the same
  // MSB-first shift serves both widths.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    word_d   = word_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = {DIV_ITER_W{1'b0}};
      rem_d    = {XLEN{1'b0}};
      quo_d    = word ? {mag_a_s[WORD_W-1:0], {(XLEN-WORD_W){1'b0}}} : mag_a_s;
      dvs_d    = mag_b_s;
      word_d   = word;
      negq_d   = neg_a_s ^ neg_b_s;
      negr_d   = neg_a_s;
    end else if (active_q) begin
      rem_d    = rem_next_s;
      quo_d    = quo_next_s;
      cnt_d    = cnt_q + 1'b1;
      active_d = ~done;
    end else begin
      active_d = 1'b0;
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q    <= {XLEN{1'b0}};
      quo_q    <= {XLEN{1'b0}};
      dvs_q    <= {XLEN{1'b0}};
      cnt_q    <= {DIV_ITER_W{1'b0}};
      active_q <= 1'b0;
      word_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      word_q   <= word_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// RV64IM execute stage: single-cycle ALU/branch/multiply, iterative divide,
// results held for the memory stage until it accepts them.
module execute_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            execute_enable,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] reg_a_contents,
  input  logic [XLEN-1:0] reg_b_contents,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      alu_op,
  input  logic            use_imm,
  input  logic            word_op,
  input  logic            downstream_ready,
  output logic [XLEN-1:0] alu_data,
  output logic [XLEN-1:0] reg_b_out,
  output logic [XLEN-1:0] pc_I_offset,
  output logic            branch_taken,
  output logic            execute_done,
  output logic            busy
);
  import pipeline_pkg::*;

  exec_state_t     state_q, state_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d, reg_b_out_q, reg_b_out_d, pc_off_q, pc_off_d;
  logic            taken_q, taken_d, done_q, done_d, rem_op_q, rem_op_d, word_q, word_d;

  alu_op_t         op_s;
  logic [XLEN-1:0] a_s, b_s, a_w_s, alu_raw_s, alu_res_s, target_s, single_res_s;
  logic [XLEN-1:0] div_a_s, div_b_s, div_sel_s;
  logic [5:0]      shamt_s;
  logic [2*XLEN-1:0] mul_a_s, mul_b_s, mul_p_s;
  logic            br_taken_s, is_div_s, is_rem_s, div_signed_s, div_start_s;
  logic            div_special_s, div_done_s;
  logic [XLEN-1:0] div_sq_s, div_sr_s, div_q_s, div_r_s;

  // Operand selection and the full-width multiplier.
  always_comb begin
    op_s    = alu_op_t'(alu_op);
    a_s     = reg_a_contents;
    b_s     = use_imm ? imm : reg_b_contents;
    a_w_s   = sext32(a_s[31:0]);
    shamt_s = word_op ? {1'b0, b_s[4:0]} : b_s[5:0];
    mul_a_s = {((op_s == OP_MULH) || (op_s == OP_MULHSU)) ? {XLEN{a_s[XLEN-1]}} : {XLEN{1'b0}}, a_s};
    mul_b_s = {(op_s == OP_MULH) ? {XLEN{b_s[XLEN-1]}} : {XLEN{1'b0}}, b_s};
    mul_p_s = mul_a_s * mul_b_s;
  end

  // Integer ALU; word forms sign-extend bit 31 of the result.
  always_comb begin
    alu_raw_s = {XLEN{1'b0}};
    case (op_s)
      OP_ADD:    alu_raw_s = a_s + b_s;
      OP_SUB:    alu_raw_s = a_s - b_s;
      OP_SLL:    alu_raw_s = a_s << shamt_s;
      OP_SLT:    alu_raw_s = {{(XLEN-1){1'b0}}, $signed(a_s) < $signed(b_s)};
      OP_SLTU:   alu_raw_s = {{(XLEN-1){1'b0}}, a_s < b_s};
      OP_XOR:    alu_raw_s = a_s ^ b_s;
      OP_SRL: begin
        if (word_op) alu_raw_s = {{(XLEN-32){1'b0}}, a_s[31:0]} >> shamt_s;
        else         alu_raw_s = a_s >> shamt_s;
      end
      OP_SRA: begin
        if (word_op) alu_raw_s = $signed(a_w_s) >>> shamt_s;
        else         alu_raw_s = $signed(a_s) >>> shamt_s;
      end
      OP_OR:     alu_raw_s = a_s | b_s;
      OP_AND:    alu_raw_s = a_s & b_s;
      OP_LUI:    alu_raw_s = imm;
      OP_AUIPC:  alu_raw_s = pc + imm;
      OP_MUL:    alu_raw_s = mul_p_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: alu_raw_s = mul_p_s[2*XLEN-1:XLEN];
      default:   alu_raw_s = {XLEN{1'b0}};
    endcase
    alu_res_s = word_op ? sext32(alu_raw_s[31:0]) : alu_raw_s;
  end

  // Branch decision, redirect target and divider operand preparation.
  always_comb begin
    case (op_s)
      OP_BEQ:         br_taken_s = (a_s == reg_b_contents);
      OP_BNE:         br_taken_s = (a_s != reg_b_contents);
      OP_BLT:         br_taken_s = ($signed(a_s) < $signed(reg_b_contents));
      OP_BGE:         br_taken_s = ($signed(a_s) >= $signed(reg_b_contents));
      OP_BLTU:        br_taken_s = (a_s < reg_b_contents);
      OP_BGEU:        br_taken_s = (a_s >= reg_b_contents);
      OP_JAL, OP_JALR: br_taken_s = 1'b1;
      default:        br_taken_s = 1'b0;
    endcase
    target_s     = (op_s == OP_JALR) ? ((a_s + imm) & ~{{(XLEN-1){1'b0}}, 1'b1}) : (pc + imm);
    is_div_s     = (op_s == OP_DIV) || (op_s == OP_DIVU) || (op_s == OP_REM) || (op_s == OP_REMU);
    is_rem_s     = (op_s == OP_REM) || (op_s == OP_REMU);
    div_signed_s = (op_s == OP_DIV) || (op_s == OP_REM);
    if (word_op) begin
      div_a_s = div_signed_s ? sext32(a_s[31:0]) : {{(XLEN-32){1'b0}}, a_s[31:0]};
      div_b_s = div_signed_s ? sext32(b_s[31:0]) : {{(XLEN-32){1'b0}}, b_s[31:0]};
    end else begin
      div_a_s = a_s;
      div_b_s = b_s;
    end
  end

  // Result that can be registered directly in IDLE (divide special cases included).
  always_comb begin
    div_sel_s = is_rem_s ? div_sr_s : div_sq_s;
    if (is_div_s) begin
      single_res_s = word_op ? sext32(div_sel_s[31:0]) : div_sel_s;
    end else if (br_taken_s && (op_s != OP_JAL) && (op_s != OP_JALR)) begin
      single_res_s = {XLEN{1'b0}};
    end else if ((op_s == OP_JAL) || (op_s == OP_JALR)) begin
      single_res_s = pc + 64'd4;
    end else if ((op_s >= OP_BEQ) && (op_s <= OP_BGEU)) begin
      single_res_s = {XLEN{1'b0}};
    end else begin
      single_res_s = alu_res_s;
    end
  end

  iterative_divider u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (div_start_s),
    .is_signed   (div_signed_s),
    .word        (word_op),
    .dividend    (div_a_s),
    .divisor     (div_b_s),
    .special     (div_special_s),
    .special_quo (div_sq_s),
    .special_rem (div_sr_s),
    .done        (div_done_s),
    .quotient    (div_q_s),
    .remainder   (div_r_s)
  );

  // Control FSM: IDLE accepts, DIV waits on the divider, DONE holds until accepted.
  always_comb begin
    state_d     = state_q;
    alu_data_d  = alu_data_q;
    reg_b_out_d = reg_b_out_q;
    pc_off_d    = pc_off_q;
    taken_d     = taken_q;
    done_d      = done_q;
    rem_op_d    = rem_op_q;
    word_d      = word_q;
    div_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (execute_enable) begin
          reg_b_out_d = reg_b_contents;
          pc_off_d    = target_s;
          taken_d     = br_taken_s;
          rem_op_d    = is_rem_s;
          word_d      = word_op;
          if (is_div_s && !div_special_s) begin
            div_start_s = 1'b1;
            state_d     = S_DIV;
          end else begin
            alu_data_d = single_res_s;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (div_done_s) begin
          if (rem_op_q) alu_data_d = word_q ? sext32(div_r_s[31:0]) : div_r_s;
          else          alu_data_d = word_q ? sext32(div_q_s[31:0]) : div_q_s;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DONE: begin
        if (downstream_ready) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      alu_data_q  <= {XLEN{1'b0}};
      reg_b_out_q <= {XLEN{1'b0}};
      pc_off_q    <= {XLEN{1'b0}};
      taken_q     <= 1'b0;
      done_q      <= 1'b0;
      rem_op_q    <= 1'b0;
      word_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_data_q  <= alu_data_d;
      reg_b_out_q <= reg_b_out_d;
      pc_off_q    <= pc_off_d;
      taken_q     <= taken_d;
      done_q      <= done_d;
      rem_op_q    <= rem_op_d;
      word_q      <= word_d;
    end
  end

  assign alu_data     = alu_data_q;
  assign reg_b_out    = reg_b_out_q;
  assign pc_I_offset  = pc_off_q;
  assign branch_taken = taken_q;
  assign execute_done = done_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit with hand-computed vectors.
module tb_execute_unit;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset, execute_enable, use_imm, word_op, downstream_ready;
  logic [63:0] pc, reg_a_contents, reg_b_contents, imm;
  logic [4:0]  alu_op;
  logic [63:0] alu_data, reg_b_out, pc_I_offset;
  logic        branch_taken, execute_done, busy;
  int          total = 0;
  int          bad = 0;
  int          lat;

  always #5 clk = ~clk;

  execute_unit dut (
    .clk(clk), .reset(reset), .execute_enable(execute_enable), .pc(pc),
    .reg_a_contents(reg_a_contents), .reg_b_contents(reg_b_contents), .imm(imm),
    .alu_op(alu_op), .use_imm(use_imm), .word_op(word_op),
    .downstream_ready(downstream_ready), .alu_data(alu_data), .reg_b_out(reg_b_out),
    .pc_I_offset(pc_I_offset), .branch_taken(branch_taken),
    .execute_done(execute_done), .busy(busy)
  );

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] im, input logic ui, input logic w, input logic [63:0] p);
    alu_op = op; reg_a_contents = a; reg_b_contents = b; imm = im;
    use_imm = ui; word_op = w; pc = p; execute_enable = 1'b1;
    tick();
    execute_enable = 1'b0;
  endtask

  task automatic wait_done(input int start, output int l);
    l = start;
    while (!execute_done && l < 200) begin
      tick();
      l++;
    end
  endtask

  task automatic run(input string tag, input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] im, input logic ui, input logic w, input logic [63:0] p,
                     input int exp_lat, input logic [63:0] exp_data);
    int l;
    drive(op, a, b, im, ui, w, p);
    wait_done(1, l);
    check_int({tag, "_lat"}, l, exp_lat);
    check64(tag, alu_data, exp_data);
  endtask

  task automatic handshake(input string tag);
    downstream_ready = 1'b1;
    tick();
    downstream_ready = 1'b0;
    check1({tag, "_done_drop"}, execute_done, 1'b0);
    check1({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; execute_enable = 1'b0; use_imm = 1'b0; word_op = 1'b0;
    downstream_ready = 1'b0; pc = 64'd0; reg_a_contents = 64'd0;
    reg_b_contents = 64'd0; imm = 64'd0; alu_op = 5'd0;
    tick(); tick();
    check64("rst_alu_data", alu_data, 64'd0);
    check64("rst_reg_b_out", reg_b_out, 64'd0);
    check64("rst_pc_off", pc_I_offset, 64'd0);
    check1("rst_taken", branch_taken, 1'b0);
    check1("rst_done", execute_done, 1'b0);
    check1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    run("add", OP_ADD, 64'd5, 64'h55, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 64'h100, 1, 64'd2);
    check64("add_target", pc_I_offset, 64'hFD);
    check64("add_regb", reg_b_out, 64'h55);
    check1("add_taken", branch_taken, 1'b0);
    check1("add_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check64("add_hold_data", alu_data, 64'd2);
      check1("add_hold_done", execute_done, 1'b1);
    end
    handshake("add");

    run("addw", OP_ADD, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1, 64'd0, 1, 64'hFFFF_FFFF_8000_0000);
    handshake("addw");
    run("sraw", OP_SRA, 64'h8000_0000, 64'd0, 64'd4, 1'b1, 1'b1, 64'd0, 1, 64'hFFFF_FFFF_F800_0000);
    handshake("sraw");
    run("sll63", OP_SLL, 64'd1, 64'd63, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'h8000_0000_0000_0000);
    handshake("sll63");
    run("sltu", OP_SLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'd1);
    handshake("sltu");
    run("slt", OP_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'd0);
    handshake("slt");
    run("mul", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFA);
    handshake("mul");
    run("mulh", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'd0);
    handshake("mulh");
    run("mulhu", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    handshake("mulhu");
    run("mulhsu", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    handshake("mulhsu");
    run("auipc", OP_AUIPC, 64'd0, 64'd0, 64'h2000, 1'b1, 1'b0, 64'h1000, 1, 64'h3000);
    handshake("auipc");

    run("div", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b0, 1'b0, 64'd0, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    handshake("div");
    run("rem", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b0, 1'b0, 64'd0, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    handshake("rem");

    drive(OP_DIVU, 64'd100, 64'd7, 64'd0, 1'b0, 1'b1, 64'd0);
    check1("divuw_busy", busy, 1'b1);
    alu_op = OP_ADD; reg_a_contents = 64'd1; reg_b_contents = 64'd99; word_op = 1'b0;
    execute_enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    execute_enable = 1'b0;
    wait_done(6, lat);
    check_int("divuw_lat", lat, 33);
    check64("divuw", alu_data, 64'd14);
    check64("divuw_regb", reg_b_out, 64'd7);
    handshake("divuw");

    run("div0", OP_DIV, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    handshake("div0");
    run("remu0", OP_REMU, 64'd123, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'd123);
    handshake("remu0");
    run("divovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'h8000_0000_0000_0000);
    handshake("divovf");
    run("removf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'd0);
    handshake("removf");

    run("blt", OP_BLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1'b0, 1'b0, 64'h1000, 1, 64'd0);
    check1("blt_taken", branch_taken, 1'b1);
    check64("blt_target", pc_I_offset, 64'h1020);
    handshake("blt");
    run("bltu", OP_BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1'b0, 1'b0, 64'h1000, 1, 64'd0);
    check1("bltu_taken", branch_taken, 1'b0);
    handshake("bltu");
    run("jalr", OP_JALR, 64'h2001, 64'd0, 64'd2, 1'b1, 1'b0, 64'h3000, 1, 64'h3004);
    check64("jalr_target", pc_I_offset, 64'h2002);
    check1("jalr_taken", branch_taken, 1'b1);
    handshake("jalr");
    run("jal", OP_JAL, 64'd0, 64'd0, 64'h100, 1'b1, 1'b0, 64'h4000, 1, 64'h4004);
    check64("jal_target", pc_I_offset, 64'h4100);
    handshake("jal");

    drive(OP_DIV, 64'd100, 64'd3, 64'd0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 29; i++) tick();
    check1("abort_pre_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check64("abort_alu_data", alu_data, 64'd0);
    check64("abort_regb", reg_b_out, 64'd0);
    check64("abort_target", pc_I_offset, 64'd0);
    check1("abort_done", execute_done, 1'b0);
    check1("abort_busy", busy, 1'b0);
    run("add_after", OP_ADD, 64'd10, 64'd20, 64'd0, 1'b0, 1'b0, 64'd0, 1, 64'd30);
    handshake("add_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
